// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file and the units
// (decode, hazard) that index it.
package gpr_pkg;

    localparam int GPR_DW = 32;
    localparam int GPR_AW = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    typedef logic [GPR_AW-1:0] reg_idx_t;

endpackage : gpr_pkg

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one busy flag per register, set on issue and
// cleared by either writeback port, with issue taking priority.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int AW = GPR_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_v,
    input  logic [AW-1:0]       iss_rd,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    output logic [(1<<AW)-1:0]  busy_vec
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] busy_q;

    // NOTE: every always_comb output gets a full default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < DEPTH; i++) begin
            // A newly issued producer outranks a writeback from an older one.
            if (iss_v && iss_rd == AW'(i)) begin
                busy_d[i] = 1'b1;
            end else if ((we0 && wa0 == AW'(i)) || (we1 && wa1 == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule : gpr_scoreboard

// File: rtl/gpr_mp.sv
// Multi-port register file with two writeback ports and a busy scoreboard.
// Define GPR_BYPASS_EN to forward same-cycle writes onto the read ports.
module gpr_mp
    import gpr_pkg::*;
#(
    parameter int DW  = GPR_DW,
    parameter int AW  = GPR_AW,
    parameter int NRD = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*DW-1:0]   rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [DW-1:0]       wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [DW-1:0]       wd1,
    input  logic                iss_v,
    input  logic [AW-1:0]       iss_rd,
    output logic [(1<<AW)-1:0]  busy_vec
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] regs_d [DEPTH];
    logic [DW-1:0] regs_q [DEPTH];
    logic [AW-1:0] ra;

    gpr_scoreboard #(
        .AW(AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_v    (iss_v),
        .iss_rd   (iss_rd),
        .we0      (we0),
        .wa0      (wa0),
        .we1      (we1),
        .wa1      (wa1),
        .busy_vec (busy_vec)
    );

    // Port 1 is applied last so a load wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (we0 && wa0 != AW'(REG_ZERO)) begin
            regs_d[wa0] = wd0;
        end
        if (we1 && wa1 != AW'(REG_ZERO)) begin
            regs_d[wa1] = wd1;
        end
        regs_d[REG_ZERO] = '0;
    end

    // NOTE: the storage array is reset because the architecture requires
    // every register to read zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = rd_addr[k*AW +: AW];
            rd_data[k*DW +: DW] = (ra == AW'(REG_ZERO)) ? '0 : regs_q[ra];
            rd_busy[k]          = busy_vec[ra];
`ifdef GPR_BYPASS_EN
            // Forwarding is suppressed in reset so reads show the cleared file.
            if (rst && ra != AW'(REG_ZERO)) begin
                if (we1 && wa1 == ra) begin
                    rd_data[k*DW +: DW] = wd1;
                end else if (we0 && wa0 == ra) begin
                    rd_data[k*DW +: DW] = wd0;
                end
                if (((we0 && wa0 == ra) || (we1 && wa1 == ra)) &&
                    !(iss_v && iss_rd == ra)) begin
                    rd_busy[k] = 1'b0;
                end
            end
`endif
        end
    end

endmodule : gpr_mp

// File: tb/tb_gpr_mp.sv
// Self-checking bench for gpr_mp: directed scenarios plus randomized traffic
// against a behavioural register/scoreboard model.
module tb_gpr_mp;
    import gpr_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRD   = 4;
    localparam int DEPTH = 1 << AW;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we0, we1, iss_v;
    logic [AW-1:0]       wa0, wa1, iss_rd;
    logic [DW-1:0]       wd0, wd1;
    logic [DEPTH-1:0]    busy_vec;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] m_reg  [DEPTH];
    logic          m_busy [DEPTH];

    always #5 clk = ~clk;

    gpr_mp #(
        .DW  (DW),
        .AW  (AW),
        .NRD (NRD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .iss_v    (iss_v),
        .iss_rd   (iss_rd),
        .busy_vec (busy_vec)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one rising edge.
    task automatic model_edge();
        if (!rst) begin
            model_reset();
        end else begin
            if (we0 && wa0 != 0) m_reg[wa0] = wd0;
            if (we1 && wa1 != 0) m_reg[wa1] = wd1;
            if (we0) m_busy[wa0] = 1'b0;
            if (we1) m_busy[wa1] = 1'b0;
            if (iss_v) m_busy[iss_rd] = 1'b1;
            m_busy[0] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef GPR_BYPASS_EN
        if (rst && we1 && wa1 == a) return wd1;
        if (rst && we0 && wa0 == a) return wd0;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic b;
        b = m_busy[a];
`ifdef GPR_BYPASS_EN
        if (rst && ((we0 && wa0 == a) || (we1 && wa1 == a)) && !(iss_v && iss_rd == a)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic check_all(input string tag);
        logic [DW-1:0]    eb;
        logic [DEPTH-1:0] ev;
        eb = '0;
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("%s rd_data[%0d]", tag, k), rd_data[k*DW +: DW],
                  exp_data(rd_addr[k*AW +: AW]));
            eb[k] = exp_busy(rd_addr[k*AW +: AW]);
        end
        check($sformatf("%s rd_busy", tag), DW'(rd_busy), eb);
        for (int i = 0; i < DEPTH; i++) ev[i] = m_busy[i];
        check($sformatf("%s busy_vec", tag), busy_vec, ev);
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_v = 1'b0; iss_rd = '0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
        rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        set_rd(5, 9, 0, 31);
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        check_all("reset");
        check("reset busy_vec zero", busy_vec, '0);
        rst = 1'b1;
        step();

        // Asynchronous reset mid-cycle after writing r5 and issuing r9
        we0 = 1'b1; wa0 = 5; wd0 = 32'hDEADBEEF;
        iss_v = 1'b1; iss_rd = 9;
        #1;
        check_all("wr r5");
        step();
        idle();
        #1;
        check_all("after wr r5");
        check("r5 written", rd_data[0 +: DW], 32'hDEADBEEF);
        check("r9 busy", DW'(rd_busy[1]), 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async reset r5", rd_data[0 +: DW], '0);
        check("async reset busy_vec", busy_vec, '0);
        check_all("async reset");
        we1 = 1'b1; wa1 = 6; wd1 = 32'h66666666;
        iss_v = 1'b1; iss_rd = 6;
        set_rd(6, 5, 9, 0);
        step();
        idle();
        #1;
        check_all("reset held");
        check("reset drops write r6", rd_data[0 +: DW], '0);
        rst = 1'b1;

        // r0 guard
        we0 = 1'b1; wa0 = 0; wd0 = 32'h1234;
        iss_v = 1'b1; iss_rd = 0;
        set_rd(0, 0, 0, 0);
        #1;
        check_all("r0 guard pre");
        step();
        idle();
        #1;
        check("r0 reads zero", rd_data[0 +: DW], '0);
        check("r0 never busy", DW'(busy_vec[0]), 0);
        check_all("r0 guard");

        // Write collision on r7, with r7 issued beforehand
        iss_v = 1'b1; iss_rd = 7;
        step();
        idle();
        we0 = 1'b1; wa0 = 7; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 7; wd1 = 32'h22222222;
        set_rd(7, 0, 0, 0);
        #1;
        check_all("collision pre");
        step();
        idle();
        #1;
        check("collision port1 wins", rd_data[0 +: DW], 32'h22222222);
        check("collision clears busy", DW'(busy_vec[7]), 0);
        check_all("collision");

        // Scoreboard sequence on r9
        iss_v = 1'b1; iss_rd = 9;
        set_rd(9, 0, 0, 0);
        step();
        idle();
        #1;
        check("sb issue sets busy", DW'(rd_busy[0]), 1);
        step();
        we1 = 1'b1; wa1 = 9; wd1 = 32'h09090909;
        iss_v = 1'b1; iss_rd = 9;
        #1;
        check_all("sb set+clear pre");
        step();
        idle();
        #1;
        check("sb set wins", DW'(rd_busy[0]), 1);
        step();
        we0 = 1'b1; wa0 = 9; wd0 = 32'h99999999;
        #1;
        check_all("sb clear pre");
        step();
        idle();
        #1;
        check("sb clear", DW'(rd_busy[0]), 0);
        check("sb data", rd_data[0 +: DW], 32'h99999999);

        // Same-cycle read of a register being written (busy producer)
        we0 = 1'b1; wa0 = 3; wd0 = 32'h00000033;
        step();
        idle();
        iss_v = 1'b1; iss_rd = 3;
        step();
        idle();
        we0 = 1'b1; wa0 = 3; wd0 = 32'hCAFEF00D;
        set_rd(3, 0, 0, 0);
        #1;
`ifdef GPR_BYPASS_EN
        check("bypass data", rd_data[0 +: DW], 32'hCAFEF00D);
        check("bypass busy", DW'(rd_busy[0]), 0);
`else
        check("no bypass data", rd_data[0 +: DW], 32'h00000033);
        check("no bypass busy", DW'(rd_busy[0]), 1);
`endif
        step();
        idle();
        #1;
        check("r3 next cycle", rd_data[0 +: DW], 32'hCAFEF00D);
        check("r3 busy cleared", DW'(rd_busy[0]), 0);

        // All four read ports
        we0 = 1'b1; wa0 = 1; wd0 = 32'd1;
        we1 = 1'b1; wa1 = 2; wd1 = 32'd2;
        step();
        idle();
        we0 = 1'b1; wa0 = REG_RA; wd0 = 32'd31;
        step();
        idle();
        set_rd(1, 2, REG_RA, REG_ZERO);
        #1;
        check("multi port0", rd_data[0*DW +: DW], 32'd1);
        check("multi port1", rd_data[1*DW +: DW], 32'd2);
        check("multi port2", rd_data[2*DW +: DW], 32'd31);
        check("multi port3", rd_data[3*DW +: DW], 32'd0);
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            we0    = ($urandom_range(0, 99) < 60);
            wa0    = rnd_addr();
            wd0    = $urandom();
            we1    = ($urandom_range(0, 99) < 40);
            wa1    = ($urandom_range(0, 3) == 0) ? wa0 : rnd_addr();
            wd1    = $urandom();
            iss_v  = ($urandom_range(0, 99) < 50);
            iss_rd = ($urandom_range(0, 3) == 0) ? wa1 : rnd_addr();
            rd_addr = {rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()};
            if ($urandom_range(0, 2) == 0) rd_addr[AW-1:0] = wa0;
            #1;
            check_all($sformatf("rand%0d", n));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_gpr_mp
